// File: rtl/axi_stream_video_src.sv
// Synthetic RGB888 test-pattern source driving an AXI-Stream master port.
// Every beat is registered; the raster position only advances on an accepted transfer.
module axi_stream_video_src #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int CNT_W      = 12,
  parameter int TLAST_MODE = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  output logic [23:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
  input  logic        m_axis_tready,
  output logic        frame_done,
  output logic [31:0] frames_sent,
  output logic        busy
);

  localparam int BAR_W = H_ACTIVE / 8;
  localparam logic [CNT_W-1:0] X_LAST   = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] Y_LAST   = CNT_W'(V_ACTIVE - 1);
  localparam logic [CNT_W-1:0] BAR_LAST = CNT_W'(BAR_W - 1);

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  x_q, x_d;
  logic [CNT_W-1:0]  y_q, y_d;
  logic [CNT_W-1:0]  barCnt_q, barCnt_d;
  logic [2:0]        barIdx_q, barIdx_d;
  logic [1:0]        pat_q, pat_d;
  logic [7:0]        solid_q, solid_d;
  logic [23:0]       tdata_q, tdata_d;
  logic              tvalid_q, tvalid_d;
  logic              tlast_q, tlast_d;
  logic              tuser_q, tuser_d;
  logic              frameDone_q, frameDone_d;
  logic [31:0]       framesSent_q, framesSent_d;

  logic              fire;
  logic              frameEnd;
  logic              loadBeat;
  logic              sofBeat;
  logic              clearBeat;
  logic              tlastHit;
  logic [23:0]       pixel;

  assign fire     = tvalid_q & m_axis_tready;
  assign frameEnd = fire & (x_q == X_LAST) & (y_q == Y_LAST);

  // Next raster position, frame accounting and whether a fresh beat is loaded.
  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    barCnt_d     = barCnt_q;
    barIdx_d     = barIdx_q;
    pat_d        = pat_q;
    solid_d      = solid_q;
    framesSent_d = framesSent_q;
    frameDone_d  = 1'b0;
    loadBeat     = 1'b0;
    sofBeat      = 1'b0;
    clearBeat    = 1'b0;

    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = STREAM;
          sofBeat = 1'b1;
        end
      end
      STREAM: begin
        if (frameEnd) begin
          framesSent_d = framesSent_q + 32'd1;
          frameDone_d  = 1'b1;
          if (enable) begin
            sofBeat = 1'b1;
          end else begin
            state_d   = IDLE;
            clearBeat = 1'b1;
            x_d       = '0;
            y_d       = '0;
            barCnt_d  = '0;
            barIdx_d  = '0;
          end
        end else if (fire) begin
          loadBeat = 1'b1;
          if (x_q == X_LAST) begin
            x_d      = '0;
            y_d      = y_q + 1'b1;
            barCnt_d = '0;
            barIdx_d = '0;
          end else begin
            x_d = x_q + 1'b1;
            // Bar index steps every BAR_W pixels without needing a divider.
            if (barCnt_q == BAR_LAST) begin
              barCnt_d = '0;
              barIdx_d = barIdx_q + 1'b1;
            end else begin
              barCnt_d = barCnt_q + 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // The solid pattern uses the completed-frame count including a frame that just ended.
    if (sofBeat) begin
      loadBeat = 1'b1;
      x_d      = '0;
      y_d      = '0;
      barCnt_d = '0;
      barIdx_d = '0;
      pat_d    = pattern_sel;
      solid_d  = framesSent_d[7:0];
    end
  end

  always_comb begin
    pixel = 24'h000000;
    case (pat_d)
      2'd0: begin
        case (barIdx_d)
          3'd0:    pixel = 24'hFFFFFF;
          3'd1:    pixel = 24'hFFFF00;
          3'd2:    pixel = 24'h00FFFF;
          3'd3:    pixel = 24'h00FF00;
          3'd4:    pixel = 24'hFF00FF;
          3'd5:    pixel = 24'hFF0000;
          3'd6:    pixel = 24'h0000FF;
          default: pixel = 24'h000000;
        endcase
      end
      2'd1:    pixel = {x_d[7:0], x_d[7:0], x_d[7:0]};
      2'd2:    pixel = (x_d[3] ^ y_d[3]) ? 24'hFFFFFF : 24'h000000;
      default: pixel = {solid_d, solid_d, solid_d};
    endcase
  end

  assign tlastHit = (x_d == X_LAST) && ((TLAST_MODE == 0) || (y_d == Y_LAST));

  // Beat registers hold their value through stalls; only loadBeat or clearBeat changes them.
  always_comb begin
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    tuser_d  = tuser_q;
    if (loadBeat) begin
      tdata_d  = pixel;
      tvalid_d = 1'b1;
      tlast_d  = tlastHit;
      tuser_d  = sofBeat;
    end else if (clearBeat) begin
      tdata_d  = 24'h000000;
      tvalid_d = 1'b0;
      tlast_d  = 1'b0;
      tuser_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      x_q          <= '0;
      y_q          <= '0;
      barCnt_q     <= '0;
      barIdx_q     <= '0;
      pat_q        <= '0;
      solid_q      <= '0;
      tdata_q      <= '0;
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
      tuser_q      <= 1'b0;
      frameDone_q  <= 1'b0;
      framesSent_q <= '0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      barCnt_q     <= barCnt_d;
      barIdx_q     <= barIdx_d;
      pat_q        <= pat_d;
      solid_q      <= solid_d;
      tdata_q      <= tdata_d;
      tvalid_q     <= tvalid_d;
      tlast_q      <= tlast_d;
      tuser_q      <= tuser_d;
      frameDone_q  <= frameDone_d;
      framesSent_q <= framesSent_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tuser  = tuser_q;
  assign frame_done    = frameDone_q;
  assign frames_sent   = framesSent_q;
  assign busy          = (state_q == STREAM);

endmodule

// File: tb/tb_axi_stream_video_src.sv
// Bench for axi_stream_video_src: two instances (line- and frame-tlast) share one stimulus
// and are compared every cycle against a beat-index model of the video raster.
module tb_axi_stream_video_src;

  localparam int H           = 16;
  localparam int V           = 4;
  localparam int FRAME_BEATS = H * V;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [1:0]  patternSel;
  logic        tready;

  logic [23:0] tdata0, tdata1;
  logic        tvalid0, tvalid1;
  logic        tlast0, tlast1;
  logic        tuser0, tuser1;
  logic        done0, done1;
  logic [31:0] frames0, frames1;
  logic        busy0, busy1;

  int vectors;
  int miscompares;

  logic        mActive;
  int          mK;
  logic [1:0]  mPat;
  logic [7:0]  mF;
  logic [31:0] mFrames;
  logic        mDone;

  int          beatCnt, tuserCnt, tlast0Cnt, tlast1Cnt, doneCnt;
  logic [23:0] cap [0:1023];

  axi_stream_video_src #(
    .H_ACTIVE(H), .V_ACTIVE(V), .CNT_W(12), .TLAST_MODE(0)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .pattern_sel(patternSel),
    .m_axis_tdata(tdata0), .m_axis_tvalid(tvalid0), .m_axis_tlast(tlast0),
    .m_axis_tuser(tuser0), .m_axis_tready(tready), .frame_done(done0),
    .frames_sent(frames0), .busy(busy0)
  );

  axi_stream_video_src #(
    .H_ACTIVE(H), .V_ACTIVE(V), .CNT_W(12), .TLAST_MODE(1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .pattern_sel(patternSel),
    .m_axis_tdata(tdata1), .m_axis_tvalid(tvalid1), .m_axis_tlast(tlast1),
    .m_axis_tuser(tuser1), .m_axis_tready(tready), .frame_done(done1),
    .frames_sent(frames1), .busy(busy1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [23:0] barColour(input int idx);
    case (idx)
      0:       return 24'hFFFFFF;
      1:       return 24'hFFFF00;
      2:       return 24'h00FFFF;
      3:       return 24'h00FF00;
      4:       return 24'hFF00FF;
      5:       return 24'hFF0000;
      6:       return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  function automatic logic [23:0] modelPixel(input logic [1:0] pat, input int k, input logic [7:0] f);
    int x;
    int y;
    logic [7:0] xb;
    x  = k % H;
    y  = k / H;
    xb = 8'(x);
    case (pat)
      2'd0:    return barColour(x / (H / 8));
      2'd1:    return {xb, xb, xb};
      2'd2:    return (((x / 8) % 2) != ((y / 8) % 2)) ? 24'hFFFFFF : 24'h000000;
      default: return {f, f, f};
    endcase
  endfunction

  // Raster model: beat index within the frame, plus frame-level start/stop rules.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mActive <= 1'b0;
      mK      <= 0;
      mPat    <= 2'd0;
      mF      <= 8'd0;
      mFrames <= 32'd0;
      mDone   <= 1'b0;
    end else begin
      mDone <= 1'b0;
      if (!mActive) begin
        if (enable) begin
          mActive <= 1'b1;
          mK      <= 0;
          mPat    <= patternSel;
          mF      <= mFrames[7:0];
        end
      end else if (tready) begin
        if (mK == FRAME_BEATS - 1) begin
          mFrames <= mFrames + 32'd1;
          mDone   <= 1'b1;
          mK      <= 0;
          if (enable) begin
            mPat <= patternSel;
            mF   <= mFrames[7:0] + 8'd1;
          end else begin
            mActive <= 1'b0;
          end
        end else begin
          mK <= mK + 1;
        end
      end
    end
  end

  // Sink-style counters and capture of every accepted beat.
  always @(posedge clk) begin
    if (rst_n && tvalid0 && tready) begin
      if (beatCnt < 1024) cap[beatCnt] <= tdata0;
      beatCnt   <= beatCnt + 1;
      tuserCnt  <= tuserCnt + int'(tuser0);
      tlast0Cnt <= tlast0Cnt + int'(tlast0);
      tlast1Cnt <= tlast1Cnt + int'(tlast1);
    end
    if (rst_n && done0) doneCnt <= doneCnt + 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: actual %h required %h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic en, input logic [1:0] pat, input logic rdy);
    enable     = en;
    patternSel = pat;
    tready     = rdy;
    tick();
  endtask

  task automatic waitFrames(input int n, input int budget, input string name, input bit randomReady);
    int seen;
    int cycles;
    seen   = 0;
    cycles = 0;
    while (seen < n && cycles < budget) begin
      if (randomReady) tready = 1'($urandom_range(0, 1));
      tick();
      cycles++;
      if (done0) seen++;
    end
    checkOutput(name, 32'(seen), 32'(n));
  endtask

  task automatic waitBeats(input int target, input int budget, input string name);
    int cycles;
    cycles = 0;
    while (beatCnt < target && cycles < budget) begin
      tick();
      cycles++;
    end
    checkOutput(name, 32'(beatCnt), 32'(target));
  endtask

  task automatic doReset();
    rst_n  = 1'b0;
    enable = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Per-cycle comparison of both instances against the model.
  initial begin
    forever begin
      @(negedge clk);
      checkOutput("tvalid0", 32'(tvalid0), 32'(mActive));
      checkOutput("tvalid1", 32'(tvalid1), 32'(mActive));
      checkOutput("busy0", 32'(busy0), 32'(mActive));
      checkOutput("busy1", 32'(busy1), 32'(mActive));
      checkOutput("frame_done0", 32'(done0), 32'(mDone));
      checkOutput("frame_done1", 32'(done1), 32'(mDone));
      checkOutput("frames_sent0", frames0, mFrames);
      checkOutput("frames_sent1", frames1, mFrames);
      if (mActive) begin
        checkOutput("tdata0", 32'(tdata0), 32'(modelPixel(mPat, mK, mF)));
        checkOutput("tdata1", 32'(tdata1), 32'(modelPixel(mPat, mK, mF)));
        checkOutput("tuser0", 32'(tuser0), 32'(mK == 0));
        checkOutput("tuser1", 32'(tuser1), 32'(mK == 0));
        checkOutput("tlast0", 32'(tlast0), 32'((mK % H) == H - 1));
        checkOutput("tlast1", 32'(tlast1), 32'(mK == FRAME_BEATS - 1));
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, vectors %0d", vectors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int b, u, l0, l1, d;
    vectors     = 0;
    miscompares = 0;
    beatCnt     = 0;
    tuserCnt    = 0;
    tlast0Cnt   = 0;
    tlast1Cnt   = 0;
    doneCnt     = 0;
    rst_n       = 1'b0;
    enable      = 1'b0;
    patternSel  = 2'd0;
    tready      = 1'b0;
    repeat (3) tick();
    checkOutput("reset_tvalid", 32'(tvalid0), 32'd0);
    checkOutput("reset_tdata", 32'(tdata0), 32'd0);
    checkOutput("reset_frames", frames0, 32'd0);
    checkOutput("reset_busy", 32'(busy0), 32'd0);
    rst_n = 1'b1;
    tick();

    // One-cycle enable pulse, colour bars, no backpressure.
    b = beatCnt; u = tuserCnt; l0 = tlast0Cnt; l1 = tlast1Cnt; d = doneCnt;
    applyStimulus(1'b1, 2'd0, 1'b1);
    enable = 1'b0;
    waitFrames(1, 200, "s1_frame", 1'b0);
    repeat (3) tick();
    checkOutput("s1_beats", 32'(beatCnt - b), 32'd64);
    checkOutput("s1_tuser", 32'(tuserCnt - u), 32'd1);
    checkOutput("s1_lines", 32'(tlast0Cnt - l0), 32'd4);
    checkOutput("s1_frames_tlast", 32'(tlast1Cnt - l1), 32'd1);
    checkOutput("s1_done", 32'(doneCnt - d), 32'd1);
    checkOutput("s1_frames_sent", frames0, 32'd1);
    checkOutput("s1_idle", 32'(tvalid0), 32'd0);
    checkOutput("s2_px0", 32'(cap[b + 0]), 32'h00FFFFFF);
    checkOutput("s2_px2", 32'(cap[b + 2]), 32'h00FFFF00);
    checkOutput("s2_px5", 32'(cap[b + 5]), 32'h0000FFFF);
    checkOutput("s2_px14", 32'(cap[b + 14]), 32'h00000000);
    checkOutput("s2_px22", 32'(cap[b + 22]), 32'h0000FF00);
    checkOutput("s2_px57", 32'(cap[b + 57]), 32'h00FF00FF);

    // Ramp under random backpressure.
    b = beatCnt; l0 = tlast0Cnt;
    applyStimulus(1'b1, 2'd1, 1'b1);
    enable = 1'b0;
    waitFrames(1, 1000, "s3_frame", 1'b1);
    tready = 1'b1;
    tick();
    checkOutput("s3_beats", 32'(beatCnt - b), 32'd64);
    checkOutput("s3_lines", 32'(tlast0Cnt - l0), 32'd4);
    checkOutput("s3_px17", 32'(cap[b + 17]), 32'h00010101);
    checkOutput("s3_px48", 32'(cap[b + 48]), 32'h00000000);
    checkOutput("s3_px63", 32'(cap[b + 63]), 32'h000F0F0F);
    checkOutput("s3_frames_sent", frames0, 32'd2);

    // Enable held across three back-to-back frames.
    b = beatCnt; u = tuserCnt; l0 = tlast0Cnt; l1 = tlast1Cnt;
    applyStimulus(1'b1, 2'd1, 1'b1);
    waitFrames(2, 400, "s4_first2", 1'b0);
    enable = 1'b0;
    waitFrames(1, 200, "s4_last", 1'b0);
    tick();
    checkOutput("s4_beats", 32'(beatCnt - b), 32'd192);
    checkOutput("s4_tuser", 32'(tuserCnt - u), 32'd3);
    checkOutput("s4_frame_tlast", 32'(tlast1Cnt - l1), 32'd3);
    checkOutput("s4_line_tlast", 32'(tlast0Cnt - l0), 32'd12);
    checkOutput("s4_frames_sent", frames0, 32'd5);

    // Pattern switch mid-frame only takes effect at the next SOF.
    doReset();
    b = beatCnt;
    applyStimulus(1'b1, 2'd2, 1'b1);
    waitBeats(b + 30, 100, "s5_beat30");
    patternSel = 2'd3;
    waitFrames(1, 200, "s5_frame1", 1'b0);
    enable = 1'b0;
    waitFrames(1, 200, "s5_frame2", 1'b0);
    tick();
    checkOutput("s5_px32", 32'(cap[b + 32]), 32'h00000000);
    checkOutput("s5_px40", 32'(cap[b + 40]), 32'h00FFFFFF);
    checkOutput("s5_f2_px0", 32'(cap[b + 64]), 32'h00010101);
    checkOutput("s5_f2_px127", 32'(cap[b + 127]), 32'h00010101);
    checkOutput("s5_frames_sent", frames0, 32'd2);

    // Asynchronous reset while a beat is stalled.
    b = beatCnt;
    applyStimulus(1'b1, 2'd0, 1'b1);
    enable = 1'b0;
    waitBeats(b + 20, 100, "s6_beat20");
    tready = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("s6_rst_tvalid0", 32'(tvalid0), 32'd0);
    checkOutput("s6_rst_tvalid1", 32'(tvalid1), 32'd0);
    checkOutput("s6_rst_frames", frames0, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    b = beatCnt;
    applyStimulus(1'b1, 2'd0, 1'b1);
    checkOutput("s6_first_tvalid", 32'(tvalid0), 32'd1);
    checkOutput("s6_first_tuser", 32'(tuser0), 32'd1);
    checkOutput("s6_first_tdata", 32'(tdata0), 32'h00FFFFFF);
    enable = 1'b0;
    waitFrames(1, 200, "s6_frame", 1'b0);
    tick();
    checkOutput("s6_beats", 32'(beatCnt - b), 32'd64);
    checkOutput("s6_frames_sent", frames0, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
